// File: rtl/shift_register_multi.sv
// shift_register_multi
//
// Multi-lane serial-to-parallel shift register with a shadow output register.
// Every enabled cycle shifts LANES bits from data_in into the shift register
// and shifts the same number of bits out on data_out, so data_out can feed
// the data_in of the next stage in a chain. Also provides a parallel capture
// path for readback, an update strobe that copies the shift register into the
// shadow register, and a per-frame beat counter with a frame-done pulse.
//
// Parameters:
//   WIDTH        shift/shadow register width (default `DATA_LEN, 8 if unset)
//   LANES        serial bits shifted per enabled cycle; must divide WIDTH
//   MSB_FIRST    1: MSB enters and leaves first, 0: LSB first
//   RESET_VALUE  value loaded into the shift and shadow registers on reset
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   data_in      [LANES]  serial input lanes
//   enable       shift LANES bits this cycle
//   update       copy shift register into shadow register
//   capture      parallel-load bit_in into the shift register
//   bit_in       [WIDTH]  parallel readback data
//   data_out     [LANES]  serial output lanes (combinational from shift register)
//   bit_out      [WIDTH]  shadow register
//   frame_done   one-cycle pulse after the shift that completes a frame
//   shift_count  beats shifted in the current frame
//   update_err   sticky flag for a rejected update
//
// Build option:
//   SHIFT_REG_FRAME_CHECK_EN  when defined, update is accepted only at a frame
//   boundary after at least one complete frame since the last accepted
//   update, capture or reset; rejected updates set the sticky update_err.
//   When undefined, update is always accepted and update_err is tied low.

`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module shift_register_multi #(
  parameter int               WIDTH       = `DATA_LEN,
  parameter int               LANES       = 1,
  parameter bit               MSB_FIRST   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LANES-1:0]     data_in,
  input  logic                 enable,
  input  logic                 update,
  input  logic                 capture,
  input  logic [WIDTH-1:0]     bit_in,
  output logic [LANES-1:0]     data_out,
  output logic [WIDTH-1:0]     bit_out,
  output logic                 frame_done,
  output logic [((WIDTH/LANES) > 1 ? $clog2(WIDTH/LANES) : 1)-1:0] shift_count,
  output logic                 update_err
);

  localparam int BEATS = WIDTH / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((WIDTH % LANES) != 0) begin : g_bad_lanes
    $error("shift_register_multi: LANES must divide WIDTH");
  end

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic             update_acc;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_inc;
  logic             wrap;
  logic             frame_done_nxt;

  // Shift direction and lane tap selection
  if (WIDTH == LANES) begin : g_full
    assign sr_shifted = data_in;
  end else if (MSB_FIRST) begin : g_msb
    assign sr_shifted = {sr[WIDTH-LANES-1:0], data_in};
  end else begin : g_lsb
    assign sr_shifted = {data_in, sr[WIDTH-1:LANES]};
  end

  if (MSB_FIRST) begin : g_out_msb
    assign data_out = sr[WIDTH-1 -: LANES];
  end else begin : g_out_lsb
    assign data_out = sr[LANES-1:0];
  end

  // An accepted update restarts the frame, so a shift in the same cycle is
  // counted as the first beat of the new frame.
  assign cnt_base       = update_acc ? '0 : shift_count;
  assign wrap           = (cnt_base == LAST_BEAT);
  assign cnt_inc        = wrap ? '0 : cnt_base + CNT_W'(1);
  assign frame_done_nxt = enable && !capture && wrap;

`ifdef SHIFT_REG_FRAME_CHECK_EN
  // Set once a full frame has been shifted; cleared when that frame is
  // consumed by an update or discarded by a capture.
  logic frame_seen;

  assign update_acc = update && (shift_count == '0) && frame_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_seen <= 1'b0;
      update_err <= 1'b0;
    end else begin
      if (update && !update_acc) update_err <= 1'b1;
      if (frame_done_nxt) frame_seen <= 1'b1;
      else if (capture || update_acc) frame_seen <= 1'b0;
    end
  end
`else
  assign update_acc = update;
  assign update_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sr          <= RESET_VALUE;
      bit_out     <= RESET_VALUE;
      shift_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_done_nxt;
      // Shadow copy uses the pre-edge shift register contents.
      if (update_acc) bit_out <= sr;
      if (capture) begin
        sr          <= bit_in;
        shift_count <= '0;
      end else if (enable) begin
        sr          <= sr_shifted;
        shift_count <= cnt_inc;
      end else begin
        shift_count <= cnt_base;
      end
    end
  end

endmodule

// File: tb/tb_shift_register_multi.sv
module tb_shift_register_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 8 bits, 1 lane, MSB first, reset value A5
  logic       a_rst = 1'b0, a_en = 1'b0, a_upd = 1'b0, a_cap = 1'b0;
  logic [7:0] a_bin = '0;
  logic [0:0] a_din = '0;
  logic [0:0] a_dout;
  logic [7:0] a_bo;
  logic       a_fd, a_err;
  logic [2:0] a_cnt;

  // DUT B: 8 bits, 2 lanes, LSB first, reset value 00
  logic       b_rst = 1'b0, b_en = 1'b0, b_upd = 1'b0, b_cap = 1'b0;
  logic [7:0] b_bin = '0;
  logic [1:0] b_din = '0;
  logic [1:0] b_dout;
  logic [7:0] b_bo;
  logic       b_fd, b_err;
  logic [1:0] b_cnt;

  shift_register_multi #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1), .RESET_VALUE(8'hA5)) dut_a (
    .clk(clk), .reset(a_rst), .data_in(a_din), .enable(a_en), .update(a_upd),
    .capture(a_cap), .bit_in(a_bin), .data_out(a_dout), .bit_out(a_bo),
    .frame_done(a_fd), .shift_count(a_cnt), .update_err(a_err));

  shift_register_multi #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0), .RESET_VALUE(8'h00)) dut_b (
    .clk(clk), .reset(b_rst), .data_in(b_din), .enable(b_en), .update(b_upd),
    .capture(b_cap), .bit_in(b_bin), .data_out(b_dout), .bit_out(b_bo),
    .frame_done(b_fd), .shift_count(b_cnt), .update_err(b_err));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one record of architectural state per instance.
  typedef struct {
    logic [7:0] sr;
    logic [7:0] bo;
    int         cnt;
    logic       fd;
    logic       err;
    logic       seen;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t step(mstate_t s, int lanes, bit msb, logic [7:0] rv,
                                   logic rst, logic en, logic upd, logic cap,
                                   logic [7:0] bin, logic [1:0] din);
    mstate_t    n = s;
    int         beats = 8 / lanes;
    int         start;
    bit         acc;
    logic [7:0] dm;
    n.fd = 1'b0;
    if (rst) begin
      n.sr = rv; n.bo = rv; n.cnt = 0; n.err = 1'b0; n.seen = 1'b0;
      return n;
    end
`ifdef SHIFT_REG_FRAME_CHECK_EN
    acc = upd && (s.cnt == 0) && (s.seen === 1'b1);
`else
    acc = upd;
`endif
    if (upd && !acc) n.err = 1'b1;
    if (acc) n.bo = s.sr;
    if (cap) begin
      n.sr = bin; n.cnt = 0; n.seen = 1'b0;
    end else begin
      start = acc ? 0 : s.cnt;
      n.cnt = start;
      if (en) begin
        dm    = 8'(din) & 8'((1 << lanes) - 1);
        n.sr  = msb ? 8'((s.sr << lanes) | dm) : 8'((s.sr >> lanes) | (dm << (8 - lanes)));
        n.cnt = (start + 1) % beats;
        n.fd  = (start + 1 == beats);
      end
      if (n.fd) n.seen = 1'b1;
      else if (acc) n.seen = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_dout(mstate_t s, int lanes, bit msb);
    return msb ? 8'(s.sr >> (8 - lanes)) : 8'(s.sr & 8'((1 << lanes) - 1));
  endfunction

  always @(posedge clk) begin
    ma <= step(ma, 1, 1'b1, 8'hA5, a_rst, a_en, a_upd, a_cap, a_bin, {1'b0, a_din});
    mb <= step(mb, 2, 1'b0, 8'h00, b_rst, b_en, b_upd, b_cap, b_bin, b_din);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_data_out",    32'(a_dout), 32'(exp_dout(ma, 1, 1'b1)));
      chk("a_bit_out",     32'(a_bo),   32'(ma.bo));
      chk("a_frame_done",  32'(a_fd),   32'(ma.fd));
      chk("a_shift_count", 32'(a_cnt),  32'(ma.cnt));
      chk("a_update_err",  32'(a_err),  32'(ma.err));
      chk("b_data_out",    32'(b_dout), 32'(exp_dout(mb, 2, 1'b0)));
      chk("b_bit_out",     32'(b_bo),   32'(mb.bo));
      chk("b_frame_done",  32'(b_fd),   32'(mb.fd));
      chk("b_shift_count", 32'(b_cnt),  32'(mb.cnt));
      chk("b_update_err",  32'(b_err),  32'(mb.err));
    end
  end

  task automatic a_cyc(input logic rst, input logic en, input logic upd, input logic cap,
                       input logic [7:0] bin, input logic din);
    a_rst = rst; a_en = en; a_upd = upd; a_cap = cap; a_bin = bin; a_din = din;
    @(posedge clk); #1;
    a_rst = 1'b0; a_en = 1'b0; a_upd = 1'b0; a_cap = 1'b0; a_bin = '0; a_din = '0;
  endtask

  task automatic b_cyc(input logic rst, input logic en, input logic upd, input logic cap,
                       input logic [7:0] bin, input logic [1:0] din);
    b_rst = rst; b_en = en; b_upd = upd; b_cap = cap; b_bin = bin; b_din = din;
    @(posedge clk); #1;
    b_rst = 1'b0; b_en = 1'b0; b_upd = 1'b0; b_cap = 1'b0; b_bin = '0; b_din = '0;
  endtask

  logic [7:0] pat_b3  = 8'hB3;
  logic [7:0] pat_cap = 8'h5A;
  logic [1:0] b_beats [4] = '{2'b11, 2'b00, 2'b01, 2'b10};

  initial begin
    // Reset both instances together
    a_rst = 1'b1; b_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0;
    chk_en = 1'b1;
    chk("reset a_bit_out",     32'(a_bo),  32'hA5);
    chk("reset a_shift_count", 32'(a_cnt), 32'h0);
    chk("reset a_frame_done",  32'(a_fd),  32'h0);
    chk("reset a_data_out",    32'(a_dout), 32'h1);
    chk("reset b_bit_out",     32'(b_bo),  32'h00);

    // Frame of 1,0,1,1,0,0,1,1 then update
    for (int i = 0; i < 8; i++) begin
      a_cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, pat_b3[7-i]);
      if (i == 6) chk("a frame_done early", 32'(a_fd), 32'h0);
    end
    chk("a frame_done 8th",  32'(a_fd),  32'h1);
    chk("a count after frame", 32'(a_cnt), 32'h0);
    a_cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("a bit_out B3",      32'(a_bo),  32'hB3);
    chk("a count after upd", 32'(a_cnt), 32'h0);
    chk("a err after upd",   32'(a_err), 32'h0);

    // Capture 5A and shift it out
    a_cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("a capture serial", 32'(a_dout), 32'(pat_cap[7-i]));
      a_cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    chk("a bit_out held", 32'(a_bo), 32'hB3);
    chk("a frame after capture", 32'(a_fd), 32'h1);

    // Reload B3, then update and enable together with data_in = 1
    for (int i = 0; i < 8; i++) a_cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, pat_b3[7-i]);
    a_cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("a upd+en bit_out", 32'(a_bo),   32'hB3);
    chk("a upd+en msb",     32'(a_dout), 32'h0);
    chk("a upd+en count",   32'(a_cnt),  32'h1);
    for (int i = 0; i < 3; i++) a_cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("a idle bit_out", 32'(a_bo),  32'hB3);
    chk("a idle count",   32'(a_cnt), 32'h1);

    // Update in the middle of a frame
    a_cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) a_cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    a_cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef SHIFT_REG_FRAME_CHECK_EN
    chk("a midframe bit_out", 32'(a_bo),  32'hA5);
    chk("a midframe err",     32'(a_err), 32'h1);
    chk("a midframe count",   32'(a_cnt), 32'h5);
    for (int i = 0; i < 3; i++) a_cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("a err sticky", 32'(a_err), 32'h1);
`else
    chk("a midframe bit_out", 32'(a_bo),  32'hBF);
    chk("a midframe err",     32'(a_err), 32'h0);
    chk("a midframe count",   32'(a_cnt), 32'h0);
    for (int i = 0; i < 3; i++) a_cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("a err stays low", 32'(a_err), 32'h0);
`endif

    // Reset after 5 shifts, with other inputs active
    for (int i = 0; i < 5; i++) a_cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    a_cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1);
    chk("a rst bit_out", 32'(a_bo),   32'hA5);
    chk("a rst count",   32'(a_cnt),  32'h0);
    chk("a rst frame",   32'(a_fd),   32'h0);
    chk("a rst err",     32'(a_err),  32'h0);
    chk("a rst dout",    32'(a_dout), 32'h1);

    // Two-lane LSB-first frame
    for (int i = 0; i < 4; i++) begin
      b_cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, b_beats[i]);
      if (i == 0) chk("b dout beat1", 32'(b_dout), 32'h0);
    end
    chk("b frame_done 4th", 32'(b_fd),   32'h1);
    chk("b count wrap",     32'(b_cnt),  32'h0);
    chk("b dout full",      32'(b_dout), 32'h3);
    b_cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
    chk("b bit_out 93", 32'(b_bo),  32'h93);
    chk("b err",        32'(b_err), 32'h0);

    // Back-to-back frames with enable held
    for (int i = 0; i < 10; i++) begin
      b_cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'(i % 4));
      if (i == 7) chk("b frame_done b2b", 32'(b_fd), 32'h1);
    end
    chk("b count b2b", 32'(b_cnt), 32'h2);
    b_cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 2'b00);
    chk("b capture count", 32'(b_cnt),  32'h0);
    chk("b capture dout",  32'(b_dout), 32'h3);

    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
